// File: rtl/cpu_pkg.sv
// Shared core definitions: stage payload layouts that callers pack into a
// pipe_stage_buf s_data bus, plus the default build settings for those buffers.
package cpu_pkg;

  // Entries per stage buffer; two is the smallest depth that still
  // sustains one transfer every cycle.
  localparam int PIPE_DEPTH_DEFAULT = 2;

  // Single-cycle builds collapse every stage buffer into wires.
  // Callers pass this value as PASS when they instantiate pipe_stage_buf.
`ifdef SINGLE_CYCLE
  localparam int PIPE_PASS_BUILD = 1;
`else
  localparam int PIPE_PASS_BUILD = 0;
`endif

  // Execute -> memory stage payload
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
  } xm_payload_t;

  // Memory -> writeback stage payload
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_write;
  } mw_payload_t;

endpackage

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: a small circular queue with valid/ready handshakes on
// both sides, a flush that squashes everything in flight, and a PASS option
// that turns the block into plain wires for single-cycle builds.
module pipe_stage_buf
  import cpu_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = PIPE_DEPTH_DEFAULT,
  parameter int PASS  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  generate
    if (PASS != 0) begin : g_pass

      // No storage: the handshake and payload flow straight through, and the
      // clock, reset and flush are deliberately ignored.
      logic unused_ctrl;

      assign s_ready     = m_ready;
      assign m_valid     = s_valid;
      assign m_data      = s_data;
      assign count       = '0;
      assign unused_ctrl = ^{clk, rst, flush};

    end else begin : g_buf

      logic [WIDTH-1:0] mem [DEPTH];
      logic [PW-1:0]    rd_ptr;
      logic [PW-1:0]    wr_ptr;
      logic [PW-1:0]    rd_ptr_next;
      logic [PW-1:0]    wr_ptr_next;
      logic [CW-1:0]    cnt;
      logic             push;
      logic             pop;

      // Handshake flags come only from registered occupancy, so s_ready never
      // depends on m_ready and there is no empty-buffer bypass path.
      always_comb begin
        s_ready = (cnt != CW'(DEPTH));
        m_valid = (cnt != '0);
        m_data  = mem[rd_ptr];
        count   = cnt;
        push    = s_valid && s_ready;
        pop     = m_valid && m_ready;
      end

      // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
      always_comb begin
        rd_ptr_next = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        wr_ptr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end

      // Queue state: reset clears storage too, flush only empties the queue
      // and wins over any transfer offered in the same cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt    <= '0;
          rd_ptr <= '0;
          wr_ptr <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
          end
        end else if (flush) begin
          cnt    <= '0;
          rd_ptr <= '0;
          wr_ptr <= '0;
        end else begin
          if (push) begin
            mem[wr_ptr] <= s_data;
            wr_ptr      <= wr_ptr_next;
          end
          if (pop) begin
            rd_ptr <= rd_ptr_next;
          end
          if (push && !pop) begin
            cnt <= cnt + CW'(1);
          end else if (pop && !push) begin
            cnt <= cnt - CW'(1);
          end
        end
      end

    end
  endgenerate

endmodule
